// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin front end for a single UART transmitter.
// Owns the transmitter from handshake until TX_Done or watchdog expiry.
module uart_tx_arbiter #(
  parameter int CLKS_PER_BIT = 87,
  parameter int TIMEOUT_CLKS = 11 * CLKS_PER_BIT + 16
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_req0_valid,
  input  logic [7:0] i_req0_byte,
  output logic       o_req0_ready,
  input  logic       i_req1_valid,
  input  logic [7:0] i_req1_byte,
  output logic       o_req1_ready,
  output logic       o_TX_Start,
  output logic [7:0] o_TX_Byte,
  input  logic       i_TX_Active,
  input  logic       i_TX_Done,
  output logic [1:0] o_grant,
  output logic       o_busy,
  output logic       o_timeout,
  output logic [7:0] o_err_count
);

  localparam int CW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CLKS - 1);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT
  } state_t;

  state_t        state;
  logic          last;
  logic [CW-1:0] cnt;
  logic          win;
  logic          fire;

  // win: 0 selects requester 0, 1 selects requester 1
  always_comb begin
    win = 1'b0;
    if (i_req0_valid && i_req1_valid) win = ~last;
    else if (i_req1_valid)            win = 1'b1;
  end

  assign fire = i_reset_n && (state == IDLE) && !i_TX_Active &&
                (i_req0_valid || i_req1_valid);

  assign o_req0_ready = fire && !win;
  assign o_req1_ready = fire && win;
  assign o_busy       = (state != IDLE);

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state       <= IDLE;
      last        <= 1'b1;
      cnt         <= '0;
      o_TX_Start  <= 1'b0;
      o_TX_Byte   <= 8'h00;
      o_grant     <= 2'b00;
      o_timeout   <= 1'b0;
      o_err_count <= 8'h00;
    end else begin
      o_TX_Start <= 1'b0;
      o_timeout  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (fire) begin
            o_TX_Byte  <= win ? i_req1_byte : i_req0_byte;
            o_grant    <= win ? 2'b10 : 2'b01;
            o_TX_Start <= 1'b1;
            state      <= LAUNCH;
          end
        end
        LAUNCH: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // done beats a coincident watchdog expiry
          if (i_TX_Done) begin
            last    <= o_grant[1];
            o_grant <= 2'b00;
            state   <= IDLE;
          end else if (cnt == LIMIT) begin
            o_timeout <= 1'b1;
            if (o_err_count != 8'hFF)
              o_err_count <= o_err_count + 8'h01;
            last    <= o_grant[1];
            o_grant <= 2'b00;
            state   <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed arbitration, watchdog
// and reset cases, plus a default-rate instance driving a UART model.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int CPB   = 2;
  localparam int T     = 11 * CPB + 16;
  localparam int S_CPB = 87;

  typedef struct packed {
    logic [7:0] b;
    logic [1:0] g;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #50 clk = ~clk;

  logic       v0, v1, r0, r1, start, act, done, busy, tmo;
  logic [7:0] b0, b1, txb, errc;
  logic [1:0] grant;

  logic       s_v0, s_v1, s_r0, s_r1, s_start, s_act, s_done;
  logic       s_busy, s_tmo, s_ser;
  logic [7:0] s_b0, s_b1, s_txb, s_errc;
  logic [1:0] s_grant;

  int checks = 0;
  int fails  = 0;
  int dual   = 0;
  int s_tmo_cnt = 0;
  longint cyc = 0;

  exp_t       sb[$];
  logic [7:0] rx_q[$];

  uart_tx_arbiter #(.CLKS_PER_BIT(CPB)) dut (
    .i_clock(clk), .i_reset_n(rst_n),
    .i_req0_valid(v0), .i_req0_byte(b0), .o_req0_ready(r0),
    .i_req1_valid(v1), .i_req1_byte(b1), .o_req1_ready(r1),
    .o_TX_Start(start), .o_TX_Byte(txb),
    .i_TX_Active(act), .i_TX_Done(done),
    .o_grant(grant), .o_busy(busy),
    .o_timeout(tmo), .o_err_count(errc)
  );

  uart_tx_arbiter #(.CLKS_PER_BIT(S_CPB)) u_sys (
    .i_clock(clk), .i_reset_n(rst_n),
    .i_req0_valid(s_v0), .i_req0_byte(s_b0), .o_req0_ready(s_r0),
    .i_req1_valid(s_v1), .i_req1_byte(s_b1), .o_req1_ready(s_r1),
    .o_TX_Start(s_start), .o_TX_Byte(s_txb),
    .i_TX_Active(s_act), .i_TX_Done(s_done),
    .o_grant(s_grant), .o_busy(s_busy),
    .o_timeout(s_tmo), .o_err_count(s_errc)
  );

  // Behavioural UART transmitter: 8N1, LSB first
  logic [8:0] sh;
  int ccnt, bcnt;
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    s_done <= 1'b0;
    if (!rst_n) begin
      s_act <= 1'b0;
      s_ser <= 1'b1;
      ccnt  <= 0;
      bcnt  <= 0;
      sh    <= '1;
    end else if (!s_act) begin
      if (s_start) begin
        s_act <= 1'b1;
        sh    <= {1'b1, s_txb};
        s_ser <= 1'b0;
        ccnt  <= 0;
        bcnt  <= 0;
      end
    end else if (ccnt != S_CPB - 1) begin
      ccnt <= ccnt + 1;
    end else begin
      ccnt <= 0;
      if (bcnt == 9) begin
        s_act  <= 1'b0;
        s_done <= 1'b1;
        s_ser  <= 1'b1;
      end else begin
        s_ser <= sh[0];
        sh    <= sh >> 1;
        bcnt  <= bcnt + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (r0 && r1) dual++;
    if (s_r0 && s_r1) dual++;
    if (s_tmo) s_tmo_cnt++;
    if (start) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        chk("tx_byte", txb, e.b);
        chk("tx_grant", grant, e.g);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic done_pulse();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  task automatic wait_start();
    int n = 0;
    while (!start && n < 50) begin
      tick();
      n++;
    end
    chk("start_seen", start, 1);
  endtask

  task automatic run_timeout(input int k);
    int n = 0;
    b0 = 8'h11;
    v0 = 1'b1;
    sb.push_back('{b: 8'h11, g: 2'b01});
    wait_start();
    v0 = 1'b0;
    tick();
    while (!tmo && n < T + 10) begin
      tick();
      n++;
    end
    chk("tmo_latency", n, T);
    chk("err_count", errc, (k > 255) ? 255 : k);
    chk("tmo_grant", grant, 0);
    tick();
    chk("tmo_pulse_len", tmo, 0);
  endtask

  task automatic rx_byte(output logic [7:0] b, output longint t0);
    int n = 0;
    while (s_ser !== 1'b0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("rx_frame_seen", s_ser, 0);
    t0 = cyc;
    repeat (S_CPB / 2) @(negedge clk);
    chk("rx_start_bit", s_ser, 0);
    for (int i = 0; i < 8; i++) begin
      repeat (S_CPB) @(negedge clk);
      b[i] = s_ser;
    end
    repeat (S_CPB) @(negedge clk);
    chk("rx_stop_bit", s_ser, 1);
  endtask

  initial begin
    #15_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] rb;
    longint ta, tb;
    rst_n = 1'b0;
    {v0, v1, act, done} = '0;
    {s_v0, s_v1} = '0;
    b0 = 8'hCD;
    b1 = 8'h00;
    s_b0 = 8'h00;
    s_b1 = 8'h00;
    v0 = 1'b1;

    // reset values and single request
    tick(2);
    chk("rst_start", start, 0);
    chk("rst_byte", txb, 8'h00);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tmo", tmo, 0);
    chk("rst_errc", errc, 0);
    chk("rst_ready", {r1, r0}, 2'b00);
    rst_n = 1'b1;
    #1;
    chk("s1_ready", {r1, r0}, 2'b01);
    sb.push_back('{b: 8'hCD, g: 2'b01});
    wait_start();
    v0 = 1'b0;
    chk("s1_ready_drop", r0, 0);
    chk("s1_busy", busy, 1);
    tick();
    chk("s1_start_len", start, 0);
    done_pulse();
    chk("s1_idle", busy, 0);
    chk("s1_grant_clr", grant, 0);
    chk("s1_byte_hold", txb, 8'hCD);

    // contention, both held
    do_reset();
    b0 = 8'h3F;
    b1 = 8'hA5;
    v0 = 1'b1;
    v1 = 1'b1;
    sb.push_back('{b: 8'h3F, g: 2'b01});
    sb.push_back('{b: 8'hA5, g: 2'b10});
    sb.push_back('{b: 8'h3F, g: 2'b01});
    for (int i = 0; i < 3; i++) begin
      wait_start();
      tick();
      done_pulse();
      chk("rr_next_ready", {r1, r0}, (i % 2 == 0) ? 2'b10 : 2'b01);
      if (i == 2) begin
        v0 = 1'b0;
        v1 = 1'b0;
      end
    end

    // transmitter busy in IDLE
    act = 1'b1;
    b1 = 8'h5A;
    v1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("act_no_ready", r1, 0);
      chk("act_idle", busy, 0);
    end
    act = 1'b0;
    #1;
    chk("act_release_ready", r1, 1);
    sb.push_back('{b: 8'h5A, g: 2'b10});
    tick();
    chk("act_grant_start", start, 1);
    v1 = 1'b0;
    tick();
    done_pulse();

    // watchdog, then saturation
    for (int k = 1; k <= 256; k++) run_timeout(k);
    chk("err_saturated", errc, 255);

    // reset in WAIT aborts and restores last=1
    b1 = 8'h99;
    v1 = 1'b1;
    sb.push_back('{b: 8'h99, g: 2'b10});
    wait_start();
    v1 = 1'b0;
    tick(4);
    v0 = 1'b1;
    v1 = 1'b1;
    b0 = 8'h77;
    b1 = 8'h88;
    rst_n = 1'b0;
    tick();
    chk("mid_rst_start", start, 0);
    chk("mid_rst_byte", txb, 8'h00);
    chk("mid_rst_grant", grant, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_tmo", tmo, 0);
    chk("mid_rst_errc", errc, 0);
    chk("mid_rst_ready", {r1, r0}, 2'b00);
    rst_n = 1'b1;
    #1;
    chk("post_rst_winner", {r1, r0}, 2'b01);
    sb.push_back('{b: 8'h77, g: 2'b01});
    wait_start();
    v0 = 1'b0;
    v1 = 1'b0;
    tick();
    done_pulse();

    // done coincident with expiry
    b0 = 8'h22;
    v0 = 1'b1;
    sb.push_back('{b: 8'h22, g: 2'b01});
    wait_start();
    v0 = 1'b0;
    tick();
    tick(T - 1);
    chk("coinc_pre_busy", busy, 1);
    done_pulse();
    chk("coinc_no_tmo", tmo, 0);
    chk("coinc_idle", busy, 0);
    chk("coinc_errc", errc, 0);
    tick();
    chk("coinc_no_tmo2", tmo, 0);

    // done during LAUNCH is ignored
    b0 = 8'h33;
    v0 = 1'b1;
    sb.push_back('{b: 8'h33, g: 2'b01});
    wait_start();
    v0 = 1'b0;
    done_pulse();
    chk("launch_done_ignored", busy, 1);
    done_pulse();
    chk("launch_then_done", busy, 0);

    // system: two queued bytes over real serial timing
    s_b0 = 8'hC3;
    s_b1 = 8'h5E;
    rx_q.push_back(8'hC3);
    rx_q.push_back(8'h5E);
    s_v0 = 1'b1;
    s_v1 = 1'b1;
    #1;
    fork
      begin
        int n = 0;
        while (!s_r0 && n < 5000) begin tick(); n++; end
        chk("sys_ready0", s_r0, 1);
        tick();
        s_v0 = 1'b0;
        n = 0;
        while (!s_r1 && n < 5000) begin tick(); n++; end
        chk("sys_ready1", s_r1, 1);
        tick();
        s_v1 = 1'b0;
      end
      begin
        rx_byte(rb, ta);
        chk("sys_byte0", rb, rx_q.pop_front());
        rx_byte(rb, tb);
        chk("sys_byte1", rb, rx_q.pop_front());
        chk("sys_b2b_gap", (tb - ta >= 10 * S_CPB) &&
                           (tb - ta <= 10 * S_CPB + 8), 1);
      end
    join
    tick(S_CPB * 2);
    chk("sys_idle", s_busy, 0);
    chk("sys_grant", s_grant, 0);
    chk("sys_errc", s_errc, 0);
    chk("sys_tmo_cnt", s_tmo_cnt, 0);

    chk("dual_ready", dual, 0);
    chk("sb_empty", sb.size(), 0);
    chk("rx_q_empty", rx_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 87, meaning clocks per UART bit; used only to derive TIMEOUT_CLKS.
REQ-002 SHALL have parameter TIMEOUT_CLKS, default 11*CLKS_PER_BIT+16, meaning max clocks to wait in WAIT for i_TX_Done.
REQ-003 SHALL have ports, one per line:
- i_clock  in  1  sole clock; all logic on rising edge.
- i_reset_n  in  1  synchronous, active-low reset.
- i_req0_valid  in  1  requester 0 has a byte.
- i_req0_byte  in  8  requester 0 data.
- o_req0_ready  out  1  requester 0 byte accepted this cycle.
- i_req1_valid  in  1  requester 1 has a byte.
- i_req1_byte  in  8  requester 1 data.
- o_req1_ready  out  1  requester 1 byte accepted this cycle.
- o_TX_Start  out  1  start pulse to UART transmitter.
- o_TX_Byte  out  8  byte to UART transmitter.
- i_TX_Active  in  1  transmitter busy.
- i_TX_Done  in  1  transmitter completion pulse.
- o_grant  out  2  one-hot owner of the transmitter; 00 when idle.
- o_busy  out  1  high in any state other than IDLE.
- o_timeout  out  1  one-cycle pulse on watchdog expiry.
- o_err_count  out  8  saturating timeout count.

Function
REQ-004 SHALL implement FSM states IDLE, LAUNCH, WAIT.
REQ-005 SHALL keep a last-served pointer `last`. When both requesters are valid, the requester not equal to `last` SHALL win. When only one is valid, that requester SHALL win.
REQ-006 In IDLE with i_TX_Active=0 and at least one valid, SHALL combinationally assert o_reqN_ready for the winner only. The handshake completes that cycle.
REQ-007 On the handshake, SHALL latch the winner's byte into o_TX_Byte, set o_grant to the winner (one-hot), and enter LAUNCH next cycle.
REQ-008 In IDLE with i_TX_Active=1, SHALL assert no ready and remain in IDLE.
REQ-009 In LAUNCH, SHALL drive o_TX_Start=1 for exactly one cycle and then enter WAIT. Latency from handshake cycle to o_TX_Start SHALL be 1 cycle.
REQ-010 o_TX_Byte SHALL hold stable from LAUNCH until the next handshake.
REQ-011 In WAIT, SHALL increment a timeout counter from 0 each cycle.
REQ-012 On i_TX_Done=1 in WAIT, SHALL return to IDLE, set `last` to the current grantee, and clear o_grant.
REQ-013 If the counter reaches TIMEOUT_CLKS-1 without i_TX_Done, SHALL:
- pulse o_timeout for one cycle;
- increment o_err_count, saturating at 255;
- update `last` and clear o_grant;
- return to IDLE.
REQ-014 If i_TX_Done and expiry occur in the same cycle, done SHALL win: no o_timeout pulse and no count increment.
REQ-015 i_TX_Done in IDLE or LAUNCH SHALL be ignored.
REQ-016 Requester valid changes outside IDLE SHALL have no effect. A new grant SHALL be possible in the first IDLE cycle after WAIT exits, giving 1 dead cycle between transfers.
REQ-017 o_ready SHALL never be asserted for both requesters in the same cycle.

Reset
REQ-018 When i_reset_n=0 at a rising edge, SHALL go to IDLE with these values:
- o_TX_Start=0, o_TX_Byte=8'h00, o_grant=2'b00;
- o_busy=0, o_timeout=0, o_err_count=0;
- timeout counter 0;
- `last`=1, so requester 0 wins the first contention.
REQ-019 Reset asserted in LAUNCH or WAIT SHALL abort the transfer with no o_timeout pulse. Ready outputs SHALL be 0 while reset is low.

Verification
REQ-020 Bench SHALL cover these directed scenarios:
- Reset, then req0 valid with 8'hCD: o_req0_ready for 1 cycle, o_TX_Start 1 cycle later with o_TX_Byte=8'hCD, o_grant=01; i_TX_Done returns to IDLE.
- Both valid, req0=8'h3F and req1=8'hA5, held: first transfer 8'h3F (req0), second 8'hA5 (req1), third req0 again; never two readys in one cycle.
- i_TX_Active held high in IDLE with req1 valid: no ready; grant occurs the cycle after i_TX_Active falls.
- No i_TX_Done after LAUNCH: o_timeout pulses exactly TIMEOUT_CLKS cycles after entering WAIT, o_err_count=1; repeat 256 times, count stays 255.
- i_TX_Done coincident with the expiry cycle: no o_timeout, o_err_count unchanged.
- Reset pulsed mid-WAIT: all outputs at reset values next cycle; next contention grants req0.
- Connected to UART_Transmitter (CLKS_PER_BIT=87, 10 MHz): two queued bytes appear back-to-back on serial with correct framing.
